// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y-86 instruction, ALU, condition and status encodings shared by the execute stage
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_t;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_INS = 3'd4;

    // flags is {ZF,SF,OF}
    function automatic logic cond_true(input logic [3:0] fn, input logic [2:0] flags);
        logic zf, sf, of;
        {zf, sf, of} = flags;
        case (fn)
            C_YES:   cond_true = 1'b1;
            C_LE:    cond_true = (sf ^ of) | zf;
            C_L:     cond_true = sf ^ of;
            C_E:     cond_true = zf;
            C_NE:    cond_true = ~zf;
            C_GE:    cond_true = ~(sf ^ of);
            C_G:     cond_true = ~(sf ^ of) & ~zf;
            default: cond_true = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational Y-86 ALU computing b OP a with {ZF,SF,OF} flags
module alu64
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_fn_t          fn,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    logic of;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = b + a;
                of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
        flags = {(result == '0), result[WIDTH-1], of};
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y-86 SEQ execute stage: operand muxing, condition codes, status FSM, result registers
module execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic [2:0]       cc,
    output logic [2:0]       stat
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] valE_q, valE_d;
    logic             cnd_q, cnd_d;
    logic [2:0]       cc_q, cc_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    alu_fn_t          alu_fn;
    logic [2:0]       alu_flags;
    logic             accept, is_cond, is_bad, cnd_raw;

    // Every non-OPq result is routed through the same adder as b +/- a
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fn = ALU_ADD;
        case (icode)
            I_RRMOVQ: alu_a = valA;
            I_IRMOVQ: alu_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC;
                alu_b = valB;
            end
            I_OPQ: begin
                alu_a  = valA;
                alu_b  = valB;
                alu_fn = alu_fn_t'(ifun[1:0]);
            end
            I_CALL, I_PUSHQ: begin
                alu_a  = WIDTH'(8);
                alu_b  = valB;
                alu_fn = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = WIDTH'(8);
                alu_b = valB;
            end
            default: ;
        endcase
    end

    alu64 #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_res),
        .flags  (alu_flags)
    );

    assign accept  = in_valid && (state_q == ST_RUN);
    assign is_cond = (icode == I_RRMOVQ) || (icode == I_JXX);
    assign is_bad  = (icode > I_POPQ) || ((icode == I_OPQ) && (ifun > 4'd3)) || (is_cond && (ifun > C_G));
    assign cnd_raw = is_cond && cond_true(ifun, cc_q);

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        valE_d      = valE_q;
        cnd_d       = cnd_q;
        cc_d        = cc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (icode == I_HALT) begin
                state_d = ST_HALT;
                valE_d  = '0;
                cnd_d   = 1'b0;
            end else if (is_bad) begin
                state_d = ST_ERR;
                valE_d  = '0;
                cnd_d   = 1'b0;
            end else begin
                valE_d = alu_res;
                cnd_d  = cnd_raw;
                if (icode == I_OPQ) begin
                    cc_d = alu_flags;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            cc_q        <= 3'b100;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            valE_q      <= valE_d;
            cnd_q       <= cnd_d;
            cc_q        <= cc_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_RUN:  stat = S_AOK;
            ST_HALT: stat = S_HLT;
            default: stat = S_INS;
        endcase
    end

    assign out_valid = out_valid_q;
    assign valE      = valE_q;
    assign cnd       = cnd_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural Y-86 execute model
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [3:0]  ifun = 4'h0;
    logic [63:0] valA = '0;
    logic [63:0] valB = '0;
    logic [63:0] valC = '0;
    logic        out_valid;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic [2:0]  stat;

    int n_checks = 0;
    int n_errors = 0;

    // model state: 0 running, 1 halted, 2 error
    int          m_st = 0;
    bit          m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    logic [63:0] m_valE = '0;
    bit          m_cnd = 1'b0;
    bit          m_ov = 1'b0;

    execute_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .valE      (valE),
        .cnd       (cnd),
        .cc        (cc),
        .stat      (stat)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit cond_model(input logic [3:0] fn);
        bit lt;
        lt = m_sf ^ m_of;
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt | m_zf;
            4'd2:    return lt;
            4'd3:    return m_zf;
            4'd4:    return !m_zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !m_zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_valE = '0; m_cnd = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_step(input bit iv, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [64:0] wide;
        m_ov = 1'b0;
        if (m_st == 0 && iv) begin
            m_ov = 1'b1;
            if (ic == 4'h0) begin
                m_st = 1; m_valE = '0; m_cnd = 1'b0;
            end else if (ic > 4'hB || (ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6)) begin
                m_st = 2; m_valE = '0; m_cnd = 1'b0;
            end else begin
                m_cnd = (ic == 4'h2 || ic == 4'h7) ? cond_model(fn) : 1'b0;
                case (ic)
                    4'h2:       m_valE = a;
                    4'h3:       m_valE = c;
                    4'h4, 4'h5: m_valE = b + c;
                    4'h8, 4'hA: m_valE = b - 64'd8;
                    4'h9, 4'hB: m_valE = b + 64'd8;
                    4'h6: begin
                        // signed 65-bit arithmetic: overflow when the true result does not fit in 64 bits
                        case (fn)
                            4'd0:    wide = {b[63], b} + {a[63], a};
                            4'd1:    wide = {b[63], b} - {a[63], a};
                            4'd2:    wide = {1'b0, b & a};
                            default: wide = {1'b0, b ^ a};
                        endcase
                        m_valE = wide[63:0];
                        m_zf = (wide[63:0] == 64'd0);
                        m_sf = wide[63];
                        m_of = (fn < 4'd2) && (wide[64] != wide[63]);
                    end
                    default:    m_valE = '0;
                endcase
            end
        end
    endtask

    function automatic logic [2:0] stat_model();
        return (m_st == 0) ? 3'd1 : (m_st == 1) ? 3'd2 : 3'd4;
    endfunction

    task automatic check_all(input string tag);
        expect_eq({tag, ".ov"},   {63'd0, out_valid}, {63'd0, m_ov});
        expect_eq({tag, ".valE"}, valE, m_valE);
        expect_eq({tag, ".cnd"},  {63'd0, cnd}, {63'd0, m_cnd});
        expect_eq({tag, ".cc"},   {61'd0, cc}, {61'd0, m_zf, m_sf, m_of});
        expect_eq({tag, ".stat"}, {61'd0, stat}, {61'd0, stat_model()});
    endtask

    task automatic exec(input string tag, input bit iv, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = iv; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        model_step(iv, ic, fn, a, b, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // asserts reset between edges, checks immediately, releases after the falling edge
    task automatic mid_reset(input string tag);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1;
        mid_reset("reset");

        exec("add", 1, 4'h6, 4'd0, 64'd5, 64'd3, 64'd0);
        expect_eq("add_valE_const", valE, 64'd8);
        expect_eq("add_cc_const", {61'd0, cc}, 64'd0);
        exec("sub_of", 1, 4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        expect_eq("sub_valE_const", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        expect_eq("sub_cc_const", {61'd0, cc}, 64'd1);
        exec("jle", 1, 4'h7, 4'd1, 64'd0, 64'd0, 64'h1234);
        expect_eq("jle_cnd_const", {63'd0, cnd}, 64'd1);
        exec("xor_z", 1, 4'h6, 4'd3, 64'hDEAD, 64'hDEAD, 64'd0);
        expect_eq("xor_cc_const", {61'd0, cc}, 64'd4);
        exec("cmove", 1, 4'h2, 4'd3, 64'h42, 64'd0, 64'd0);
        expect_eq("cmove_valE_const", valE, 64'h42);
        exec("cmovne", 1, 4'h2, 4'd4, 64'h42, 64'd0, 64'd0);
        exec("idle", 0, 4'h6, 4'd0, 64'd9, 64'd9, 64'd0);
        exec("pushq", 1, 4'hA, 4'd0, 64'd0, 64'h100, 64'd0);
        expect_eq("pushq_valE_const", valE, 64'hF8);
        exec("popq", 1, 4'hB, 4'd0, 64'd0, 64'd0, 64'd0);
        exec("rmmovq", 1, 4'h4, 4'd0, 64'd0, 64'h10, 64'hF);
        expect_eq("rmmovq_valE_const", valE, 64'h1F);
        exec("halt", 1, 4'h0, 4'd0, 64'd7, 64'd7, 64'd7);
        expect_eq("halt_stat_const", {61'd0, stat}, 64'd2);
        exec("post_halt", 1, 4'h6, 4'd0, 64'd1, 64'd1, 64'd0);
        mid_reset("halt_rst");
        exec("bad_icode", 1, 4'hC, 4'd0, 64'd1, 64'd1, 64'd1);
        expect_eq("bad_icode_stat_const", {61'd0, stat}, 64'd4);
        exec("post_err", 1, 4'h6, 4'd0, 64'd1, 64'd1, 64'd0);
        mid_reset("err_rst1");
        exec("pre_bad", 1, 4'h6, 4'd1, 64'd3, 64'd1, 64'd0);
        exec("bad_ifun", 1, 4'h6, 4'd4, 64'd1, 64'd1, 64'd0);
        exec("post_err2", 1, 4'h2, 4'd0, 64'd1, 64'd1, 64'd0);
        mid_reset("err_rst2");

        for (int i = 0; i < 800; i++) begin
            if ((m_st != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                int          r;
                logic [3:0]  ic, fn;
                r = $urandom_range(0, 99);
                if (r < 2)      ic = 4'h0;
                else if (r < 4) ic = 4'($urandom_range(12, 15));
                else            ic = 4'($urandom_range(1, 11));
                if (ic == 4'h6)
                    fn = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                else if (ic == 4'h2 || ic == 4'h7)
                    fn = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
                else
                    fn = 4'($urandom_range(0, 15));
                exec("rnd", ($urandom_range(0, 3) != 0), ic, fn, rnd64(), rnd64(), rnd64());
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the Y-86 SEQ processor, directly downstream of `decode`. Takes `icode`/`ifun` from `fetch`, `valA`/`valB` from `decode` and `valC` from `fetch`, and computes `valE` with the 64-bit ALU. It evaluates the branch/cmov condition `cnd` and owns the condition-code register (ZF/SF/OF). Results are registered for the memory/write-back stages, and the block tracks processor status (AOK/HLT/INS).

## Interface
Parameters:
- `WIDTH`, 64, datapath width; the spec covers only 64.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded instruction present this cycle
- `icode`  in  4  instruction code
- `ifun`  in  4  function code
- `valA`  in  64  operand A from decode
- `valB`  in  64  operand B from decode
- `valC`  in  64  constant from fetch
- `out_valid`  out  1  registered result valid (one-cycle pulse per accepted instruction)
- `valE`  out  64  registered ALU result
- `cnd`  out  1  registered condition result
- `cc`  out  3  current {ZF,SF,OF}
- `stat`  out  3  status: 1 = AOK, 2 = HLT, 4 = INS

## Operation
- An instruction is accepted when `in_valid` = 1 and the state is RUN.
- `valE` by icode. All arithmetic is mod 2^64; there is no saturation.
  - 0 halt, 1 nop, 7 jXX: `valE` = 0.
  - 2 rrmovq/cmovXX: `valE` = valA.
  - 3 irmovq: `valE` = valC.
  - 4 rmmovq, 5 mrmovq: `valE` = valB + valC.
  - 6 OPq, by ifun: 0 → valB+valA, 1 → valB−valA, 2 → valB&valA, 3 → valB^valA.
  - 8 call, A pushq: `valE` = valB − 8.
  - 9 ret, B popq: `valE` = valB + 8.
- `cnd` applies only to icode 2 and 7; it is 0 for all other icodes.
  - Evaluated from the CC value before this instruction's update.
  - By ifun: 0 → 1; 1 le → (SF^OF)|ZF; 2 l → SF^OF; 3 e → ZF; 4 ne → ~ZF; 5 ge → ~(SF^OF); 6 g → ~(SF^OF)&~ZF.
- CC update: only an accepted OPq writes CC, at the same edge as its result.
  - ZF = (result == 0); SF = result[63].
  - OF for add: valA[63]==valB[63] && result[63]!=valB[63].
  - OF for sub: valA[63]!=valB[63] && result[63]!=valB[63].
  - OF for and/xor: 0.
- State machine states: RUN, HALT, ERR.
  - RUN → HALT on an accepted icode 0.
  - RUN → ERR on an accepted icode > B, OPq with ifun > 3, or icode 2/7 with ifun > 6.
  - HALT and ERR are sticky until reset. `in_valid` is ignored there; `out_valid` stays 0 and `valE`/`cnd`/`cc` hold.
- `stat` = 1 in RUN, 2 in HALT, 4 in ERR.
- Terminal instruction:
  - The halting instruction produces one `out_valid` pulse with `valE` = 0, `cnd` = 0.
  - The erroring instruction produces one `out_valid` pulse with `valE` = 0, `cnd` = 0. It does not update CC.

## Timing
- Latency: accepted at edge N; `valE`, `cnd`, `out_valid` and the new `cc` are visible after edge N. Throughput is one instruction per cycle.
- `stat` changes at the same edge as the terminal instruction's `out_valid`.
- `out_valid` = 0 in any cycle with no accepted instruction. `valE` and `cnd` hold their last values.
- Reset (`rst_n` = 0, asynchronous, including mid-stream):
  - `out_valid` = 0, `valE` = 0, `cnd` = 0.
  - `cc` = {ZF=1,SF=0,OF=0}.
  - State RUN, `stat` = 1.
  - No instruction in flight survives reset.
- Operation resumes on the first rising edge after `rst_n` deasserts.
- Back-to-back OPq then cmov/jXX: the second instruction sees the CC written by the first, one cycle earlier.

## Structure
- Package `y86_pkg` holds:
  - icode constants: I_HALT…I_POPQ.
  - ALU function codes: ALU_ADD/SUB/AND/XOR.
  - Condition codes: C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G.
  - Status codes: S_AOK=1, S_HLT=2, S_INS=4.
- Sub-module `alu64` is combinational: inputs a, b, fn; outputs result and {zf,sf,of}.
- `execute_stage` contains the operand muxing, condition logic, CC register, state FSM and output registers.

## Test plan
- Reset, then OPq add (icode 6, ifun 0), valA = 5, valB = 3 → next cycle `valE` = 8, `cc` = 000, `out_valid` = 1, `stat` = 1.
- OPq sub, valA = 1, valB = 0x8000_0000_0000_0000 → `valE` = 0x7FFF_FFFF_FFFF_FFFF, OF = 1, SF = 0, ZF = 0. A following jXX le (ifun 1) gives `cnd` = 1.
- OPq xor, valA = valB = 0xDEAD → ZF = 1. Next cycle cmove (icode 2, ifun 3), valA = 0x42 → `valE` = 0x42, `cnd` = 1; cmovne gives `cnd` = 0.
- pushq, valB = 0x100 → `valE` = 0xF8. popq, valB = 0 → `valE` = 8. rmmovq, valB = 0x10, valC = 0xF → `valE` = 0x1F. CC unchanged throughout.
- halt accepted → one `out_valid` pulse, `stat` = 2. A subsequent OPq with `in_valid` = 1 → `out_valid` = 0 and `cc` unchanged. Pulse `rst_n` low mid-cycle → immediately `stat` = 1, `cc` = 100.
- icode 0xC, or OPq with ifun 4 → `stat` = 4 after the edge, CC unchanged, further input ignored until reset.
